// File: rtl/da_slice_feeder.sv
// da_slice_feeder: 64-tap sample delay line that feeds a DA FIR core one MSB-first bit-slice
// per handshake, eight 8-bit LUT addresses per slice.
module da_slice_feeder #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] x_in,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic          flush,
  output logic [7:0]    A7,
  output logic [7:0]    A6,
  output logic [7:0]    A5,
  output logic [7:0]    A4,
  output logic [7:0]    A3,
  output logic [7:0]    A2,
  output logic [7:0]    A1,
  output logic [7:0]    A0,
  output logic          slice_valid,
  input  logic          slice_ready,
  output logic          slice_msb,
  output logic          slice_last,
  output logic          frame_done,
  output logic          busy
);
  localparam int BW = $clog2(DW);
  typedef enum logic {IDLE, SLICE} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_tap [64];
  logic [BW-1:0] r_bit;
  logic          r_done;
  logic          w_idle, w_accept, w_fire, w_end;
  logic [7:0]    w_a [8];
  assign w_idle      = r_state == IDLE;
  assign w_accept    = w_idle & x_valid & ~flush;
  assign w_fire      = slice_valid & slice_ready;
  assign w_end       = r_bit == '0;
  assign x_ready     = resetn & w_idle & ~flush;
  assign slice_valid = resetn & ~w_idle;
  assign busy        = slice_valid;
  assign slice_msb   = slice_valid & (r_bit == BW'(DW - 1));
  assign slice_last  = slice_valid & w_end;
  assign frame_done  = r_done;
  always_comb begin
    w_next = w_idle ? (w_accept ? SLICE : IDLE) : ((w_fire & w_end) ? IDLE : SLICE);
  end
  // Address bit k of Aj comes from tap 8j+k at the current bit position.
  always_comb begin
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++)
        w_a[j][k] = slice_valid & r_tap[8*j+k][r_bit];
  end
  assign {A7, A6, A5, A4, A3, A2, A1, A0} = {w_a[7], w_a[6], w_a[5], w_a[4], w_a[3], w_a[2], w_a[1], w_a[0]};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < 64; i++) r_tap[i] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_fire & w_end;
      if (w_idle & flush) begin
        for (int i = 0; i < 64; i++) r_tap[i] <= '0;
      end else if (w_accept) begin
        r_tap[0] <= x_in;
        for (int i = 1; i < 64; i++) r_tap[i] <= r_tap[i-1];
        r_bit <= BW'(DW - 1);
      end else if (w_fire & ~w_end) begin
        r_bit <= r_bit - BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_da_slice_feeder.sv
// tb_da_slice_feeder: directed and randomized frames checked against a tap-array model
// of the feeder's delay line and slice addressing.
module tb_da_slice_feeder;
  localparam int DW = 16;
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          x_valid = 1'b0;
  logic          flush = 1'b0;
  logic          slice_ready = 1'b0;
  logic          x_ready, slice_valid, slice_msb, slice_last, frame_done, busy;
  logic [7:0]    A7, A6, A5, A4, A3, A2, A1, A0;
  logic [63:0]   obs_a;
  logic [DW-1:0] m_tap [64];
  int            checks = 0;
  int            failures = 0;

  da_slice_feeder #(.DW(DW)) dut (
    .clk(clk), .resetn(resetn), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .flush(flush), .A7(A7), .A6(A6), .A5(A5), .A4(A4), .A3(A3), .A2(A2), .A1(A1), .A0(A0),
    .slice_valid(slice_valid), .slice_ready(slice_ready), .slice_msb(slice_msb),
    .slice_last(slice_last), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs_a = {A7, A6, A5, A4, A3, A2, A1, A0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_slice(input int b);
    logic [63:0] r;
    for (int t = 0; t < 64; t++) r[t] = m_tap[t][b];
    return r;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 64; t++) m_tap[t] = '0;
  endtask

  task automatic model_push(input logic [DW-1:0] x);
    for (int t = 63; t > 0; t--) m_tap[t] = m_tap[t-1];
    m_tap[0] = x;
  endtask

  // Pushes one sample and walks its whole frame; stall_len cycles of backpressure at slice stall_at.
  task automatic run_frame(input logic [DW-1:0] x, input int stall_at, input int stall_len);
    int t = 0;
    int cyc = 0;
    while (!x_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("x_ready_wait", 64'(x_ready), 64'd1);
    x_in = x;
    x_valid = 1'b1;
    slice_ready = 1'b1;
    @(negedge clk);
    cyc++;
    x_valid = 1'b0;
    x_in = DW'($urandom);
    model_push(x);
    for (int b = DW - 1; b >= 0; b--) begin
      if (b == stall_at) begin
        slice_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_a", obs_a, exp_slice(b));
          chk("stall_msb_last", {62'd0, slice_msb, slice_last}, {62'd0, b == DW - 1, b == 0});
          chk("stall_valid", 64'(slice_valid), 64'd1);
          @(negedge clk);
          cyc++;
        end
        slice_ready = 1'b1;
      end
      chk("slice_valid", 64'(slice_valid), 64'd1);
      chk("slice_a", obs_a, exp_slice(b));
      chk("msb_last", {62'd0, slice_msb, slice_last}, {62'd0, b == DW - 1, b == 0});
      chk("x_ready_busy", {62'd0, x_ready, frame_done}, 64'd0);
      @(negedge clk);
      cyc++;
    end
    chk("frame_done_pulse", 64'(frame_done), 64'd1);
    chk("x_ready_after", {62'd0, x_ready, busy}, {62'd0, 1'b1, 1'b0});
    chk("frame_period", 64'(cyc), 64'(DW + 1 + ((stall_at >= 0) ? stall_len : 0)));
    slice_ready = 1'($urandom);
    @(negedge clk);
    chk("frame_done_once", {62'd0, frame_done, slice_valid}, 64'd0);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_outs", {obs_a, x_ready, slice_valid, busy, frame_done} == 68'd0 ? 64'd0 : 64'd1, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset", {60'd0, x_ready, slice_valid, busy, frame_done}, {60'd0, 4'b1000});
    run_frame(16'h8001, -1, 0);
    run_frame(16'h0003, -1, 0);
    chk("two_frame_a0_bit1", 64'(exp_slice(1)), 64'h01);
    run_frame(16'h1234, 7, 5);
    for (int n = 0; n < 64; n++) run_frame(16'hFFFF, -1, 0);
    chk("fill_model", exp_slice(0), {64{1'b1}});
    run_frame(16'h0000, -1, 0);
    chk("fill65_model", exp_slice(5), {{56{1'b1}}, 8'hFE});
    flush = 1'b1;
    x_valid = 1'b1;
    x_in = 16'hBEEF;
    #1;
    chk("flush_x_ready", 64'(x_ready), 64'd0);
    @(negedge clk);
    chk("flush_no_accept", {62'd0, busy, slice_valid}, 64'd0);
    flush = 1'b0;
    x_valid = 1'b0;
    model_clear();
    run_frame(16'h0001, -1, 0);
    chk("flush_slice0_model", exp_slice(0), 64'h01);
    for (int n = 0; n < 6; n++) run_frame(DW'($urandom), $urandom_range(0, 15) - 2, $urandom_range(1, 4));
    // Reset mid-frame at slice 9.
    x_in = DW'($urandom);
    x_valid = 1'b1;
    slice_ready = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (DW - 1 - 9) @(negedge clk);
    chk("pre_reset_msb", 64'(slice_msb), 64'd0);
    resetn = 1'b0;
    #1;
    chk("rst_mid_outs", {obs_a, x_ready, slice_valid, busy} == 67'd0 ? 64'd0 : 64'd1, 64'd0);
    @(negedge clk);
    chk("rst_mid_hold", {61'd0, x_ready, slice_valid, frame_done}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_done", {62'd0, frame_done, x_ready}, {62'd0, 2'b01});
    model_clear();
    run_frame(16'h8421, -1, 0);
    chk("taps_cleared_model", exp_slice(15), 64'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
